// File: rtl/icp_run_ctrl.sv
// icp_run_ctrl: holds the icp core in reset, loads a program into shared RAM, runs it under a cycle timeout, reads back the result
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_start, i_prog_len                   launch a load+run (IDLE/DONE only), program length in words
//   i_ld_valid, i_ld_data, o_ld_ready     program word stream
//   o_core_rst, i_core_*, o_core_data_in  core control and its RAM request port
//   o_mem_*, i_mem_data                   the single shared RAM port (1-cycle read latency)
//   o_busy, o_done, o_timeout, o_result, o_cycles  run status and result
module icp_run_ctrl #(
  parameter int          LEN_W       = 10,
  parameter int          CYC_W       = 16,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] RESULT_ADDR = 32'd0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_prog_len,
  input  logic             i_ld_valid,
  input  logic [31:0]      i_ld_data,
  output logic             o_ld_ready,
  output logic             o_core_rst,
  input  logic             i_core_read_en,
  input  logic [31:0]      i_core_read_addr,
  output logic [31:0]      o_core_data_in,
  input  logic             i_core_write_en,
  input  logic [31:0]      i_core_write_addr,
  input  logic [31:0]      i_core_data_out,
  input  logic             i_core_halted,
  output logic             o_mem_read_en,
  output logic [31:0]      o_mem_read_addr,
  input  logic [31:0]      i_mem_data,
  output logic             o_mem_write_en,
  output logic [31:0]      o_mem_write_addr,
  output logic [31:0]      o_mem_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [31:0]      o_result,
  output logic [CYC_W-1:0] o_cycles
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_RB_REQ, S_RB_WAIT, S_DONE} state_t;
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] TO_VAL  = CYC_W'(TIMEOUT);
  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        result_q, result_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               run, ld_fire, start_ok;
  logic [31:0]        ld_addr;
  assign run      = state_q == S_RUN;
  assign ld_fire  = state_q == S_LOAD && i_ld_valid;
  assign start_ok = i_start && (state_q == S_IDLE || state_q == S_DONE);
  assign ld_addr  = {{(30-LEN_W){1'b0}}, idx_q, 2'b00};
  // The core owns the RAM port only while running; otherwise its requests are dropped.
  assign o_mem_write_en   = run ? i_core_write_en   : ld_fire;
  assign o_mem_write_addr = run ? i_core_write_addr : ld_addr;
  assign o_mem_data       = run ? i_core_data_out   : i_ld_data;
  assign o_mem_read_en    = run ? i_core_read_en    : state_q == S_RB_REQ;
  assign o_mem_read_addr  = run ? i_core_read_addr  : RESULT_ADDR;
  assign o_core_data_in   = i_mem_data;
  assign o_core_rst       = !run;
  assign o_ld_ready       = state_q == S_LOAD;
  assign o_busy           = state_q == S_LOAD || run || state_q == S_RB_REQ || state_q == S_RB_WAIT;
  assign o_done           = state_q == S_DONE;
  assign o_timeout        = timeout_q;
  assign o_result         = result_q;
  assign o_cycles         = cycles_q;
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) begin
        len_d     = i_prog_len;
        idx_d     = '0;
        timeout_d = 1'b0;
        result_d  = '0;
        cycles_d  = '0;
        state_d   = i_prog_len == '0 ? S_RUN : S_LOAD;
      end
      S_LOAD: if (ld_fire) begin
        idx_d   = idx_q + LEN_W'(1);
        state_d = idx_q == len_q - LEN_W'(1) ? S_RUN : S_LOAD;
      end
      // Halt is checked first so a halt on the last allowed cycle still reads back.
      S_RUN: if (i_core_halted) state_d = S_RB_REQ;
        else if (cycles_q == TO_LAST) begin
          cycles_d  = TO_VAL;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else cycles_d = cycles_q + CYC_W'(1);
      S_RB_REQ: state_d = S_RB_WAIT;
      S_RB_WAIT: begin
        result_d = i_mem_data;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      result_q  <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
    end
endmodule
